// File: rtl/ttl_out_array.sv
// ttl_out_array: per-channel TTL pattern words for external serializers, with level and one-shot hold modes.
// Optional global level override is compiled in when TTL_OUT_OVERRIDE_EN is defined.
module ttl_out_array #(
    parameter int NUM_CH    = 8,
    parameter int SER_WIDTH = 8,
    parameter int LEN_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        data_valid,
    input  logic [NUM_CH*SER_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]           ch_mask,
    input  logic [NUM_CH-1:0]           mode_oneshot,
    input  logic [NUM_CH-1:0]           invert,
    input  logic [LEN_W-1:0]            hold_len,
    input  logic                        override_en,
    input  logic [NUM_CH-1:0]           override_value,
    output logic [NUM_CH*SER_WIDTH-1:0] ser_data,
    output logic [NUM_CH-1:0]           level,
    output logic [NUM_CH-1:0]           busy,
    output logic                        collision
);

    logic [NUM_CH-1:0]           last_q;
    logic [NUM_CH-1:0]           last_d;
    logic [LEN_W-1:0]            timer_q [NUM_CH];
    logic [LEN_W-1:0]            timer_d [NUM_CH];
    logic [NUM_CH*SER_WIDTH-1:0] ser_d;
    logic [NUM_CH-1:0]           busy_d;
    logic                        hit_d;
    logic                        ovr_on;
    logic [NUM_CH-1:0]           ovr_val;

`ifdef TTL_OUT_OVERRIDE_EN
    assign ovr_on  = override_en;
    assign ovr_val = override_value;
`else
    // Override ports stay on the boundary but are deliberately left unconnected to any logic.
    logic unused_override;
    assign unused_override = ^{override_en, override_value};
    assign ovr_on  = 1'b0;
    assign ovr_val = '0;
`endif

    // Next-state per channel: override beats load, load beats the one-shot countdown.
    always_comb begin
        hit_d = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            logic [SER_WIDTH-1:0] word;
            logic                 msb;
            word       = {SER_WIDTH{last_q[c]}};
            msb        = data_in[c*SER_WIDTH + SER_WIDTH - 1];
            last_d[c]  = last_q[c];
            timer_d[c] = '0;
            if (ovr_on) begin
                word      = {SER_WIDTH{ovr_val[c]}};
                last_d[c] = ovr_val[c];
            end else if (data_valid && ch_mask[c]) begin
                word = data_in[c*SER_WIDTH +: SER_WIDTH];
                if (timer_q[c] != '0) begin
                    hit_d = 1'b1;
                end
                if (mode_oneshot[c]) begin
                    // A zero hold length means the loaded word is the whole pulse.
                    last_d[c]  = msb & (|hold_len);
                    timer_d[c] = msb ? hold_len : '0;
                end else begin
                    last_d[c] = msb;
                end
            end else if (mode_oneshot[c] && timer_q[c] != '0) begin
                timer_d[c] = timer_q[c] - 1'b1;
                if (timer_q[c] == LEN_W'(1)) begin
                    last_d[c] = 1'b0;
                end
            end
            ser_d[c*SER_WIDTH +: SER_WIDTH] = word ^ {SER_WIDTH{invert[c]}};
            busy_d[c] = (timer_d[c] != '0);
        end
    end

    // All outputs are registered so every input reaches the pins exactly one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q    <= '0;
            ser_data  <= '0;
            level     <= '0;
            busy      <= '0;
            collision <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                timer_q[c] <= '0;
            end
        end else begin
            last_q    <= last_d;
            ser_data  <= ser_d;
            level     <= last_d ^ invert;
            busy      <= busy_d;
            collision <= hit_d;
            for (int c = 0; c < NUM_CH; c++) begin
                timer_q[c] <= timer_d[c];
            end
        end
    end

endmodule

// File: tb/tb_ttl_out_array.sv
// tb_ttl_out_array: directed scenarios plus randomized traffic for ttl_out_array,
// checked against a cycle-level behavioural model of each channel's pulse.
module tb_ttl_out_array;

    localparam int NUM_CH    = 8;
    localparam int SER_WIDTH = 8;
    localparam int LEN_W     = 16;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        data_valid;
    logic [NUM_CH*SER_WIDTH-1:0] data_in;
    logic [NUM_CH-1:0]           ch_mask;
    logic [NUM_CH-1:0]           mode_oneshot;
    logic [NUM_CH-1:0]           invert;
    logic [LEN_W-1:0]            hold_len;
    logic                        override_en;
    logic [NUM_CH-1:0]           override_value;
    logic [NUM_CH*SER_WIDTH-1:0] ser_data;
    logic [NUM_CH-1:0]           level;
    logic [NUM_CH-1:0]           busy;
    logic                        collision;

    int checks = 0;
    int errors = 0;

    // Model state: current idle level and remaining high-hold cycles per channel.
    bit                          m_last [NUM_CH];
    int                          m_left [NUM_CH];
    logic [NUM_CH*SER_WIDTH-1:0] exp_ser;
    logic [NUM_CH-1:0]           exp_level;
    logic [NUM_CH-1:0]           exp_busy;
    logic                        exp_coll;

    ttl_out_array #(
        .NUM_CH   (NUM_CH),
        .SER_WIDTH(SER_WIDTH),
        .LEN_W    (LEN_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_valid    (data_valid),
        .data_in       (data_in),
        .ch_mask       (ch_mask),
        .mode_oneshot  (mode_oneshot),
        .invert        (invert),
        .hold_len      (hold_len),
        .override_en   (override_en),
        .override_value(override_value),
        .ser_data      (ser_data),
        .level         (level),
        .busy          (busy),
        .collision     (collision)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_last[c] = 1'b0;
            m_left[c] = 0;
        end
        exp_ser   = '0;
        exp_level = '0;
        exp_busy  = '0;
        exp_coll  = 1'b0;
    endfunction

    function automatic void model_cycle();
        logic ovr;
        ovr = 1'b0;
`ifdef TTL_OUT_OVERRIDE_EN
        ovr = override_en;
`endif
        exp_coll = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            logic [SER_WIDTH-1:0] w;
            if (ovr) begin
                w         = {SER_WIDTH{override_value[c]}};
                m_last[c] = override_value[c];
                m_left[c] = 0;
            end else if (data_valid && ch_mask[c]) begin
                w = data_in[c*SER_WIDTH +: SER_WIDTH];
                if (m_left[c] != 0) exp_coll = 1'b1;
                if (mode_oneshot[c]) begin
                    m_left[c] = w[SER_WIDTH-1] ? int'(hold_len) : 0;
                    m_last[c] = (m_left[c] > 0);
                end else begin
                    m_last[c] = w[SER_WIDTH-1];
                    m_left[c] = 0;
                end
            end else begin
                w = {SER_WIDTH{m_last[c]}};
                if (!mode_oneshot[c]) begin
                    m_left[c] = 0;
                end else if (m_left[c] > 0) begin
                    m_left[c] = m_left[c] - 1;
                    if (m_left[c] == 0) m_last[c] = 1'b0;
                end
            end
            exp_ser[c*SER_WIDTH +: SER_WIDTH] = w ^ {SER_WIDTH{invert[c]}};
            exp_level[c] = m_last[c] ^ invert[c];
            exp_busy[c]  = (m_left[c] > 0);
        end
    endfunction

    task automatic check_all(input string phase);
        check_output({phase, " ser_data"},  128'(ser_data),  128'(exp_ser));
        check_output({phase, " level"},     128'(level),     128'(exp_level));
        check_output({phase, " busy"},      128'(busy),      128'(exp_busy));
        check_output({phase, " collision"}, 128'(collision), 128'(exp_coll));
    endtask

    // Inputs are set by the caller before this; the model then predicts the post-edge outputs.
    task automatic apply_stimulus(input string phase);
        model_cycle();
        @(posedge clk);
        #1;
        check_all(phase);
    endtask

    task automatic load_channel(input int c, input logic [SER_WIDTH-1:0] w);
        data_valid = 1'b1;
        ch_mask    = '0;
        ch_mask[c] = 1'b1;
        data_in    = '0;
        data_in[c*SER_WIDTH +: SER_WIDTH] = w;
    endtask

    task automatic idle_inputs();
        data_valid = 1'b0;
        ch_mask    = '0;
    endtask

    logic [7:0] pulse_exp [5];
    logic       busy_exp  [5];

    initial begin
        reset          = 1'b1;
        data_valid     = 1'b0;
        data_in        = '0;
        ch_mask        = '0;
        mode_oneshot   = '0;
        invert         = '1;
        hold_len       = '0;
        override_en    = 1'b0;
        override_value = '0;
        model_reset();

        #12;
        check_all("reset");
        #10;
        check_all("reset_held");

        // Only channel 3 inverted, no loads: it idles high after reset.
        invert = 8'h08;
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus("invert_idle");
        check_output("invert_idle byte3", 128'(ser_data[31:24]), 128'(8'hFF));
        check_output("invert_idle level3", 128'(level[3]), 128'(1'b1));

        // Level mode: the loaded word, then its last bit held.
        invert = '0;
        load_channel(0, 8'hF0);
        apply_stimulus("level_load");
        check_output("level_load byte0", 128'(ser_data[7:0]), 128'(8'hF0));
        idle_inputs();
        apply_stimulus("level_hold");
        check_output("level_hold byte0", 128'(ser_data[7:0]), 128'(8'hFF));
        check_output("level_hold level0", 128'(level[0]), 128'(1'b1));

        // One-shot with hold 3 on channel 2.
        pulse_exp = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        busy_exp  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        mode_oneshot = 8'h06;
        hold_len     = 16'd3;
        load_channel(2, 8'h80);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus("oneshot");
            check_output("oneshot byte2", 128'(ser_data[23:16]), 128'(pulse_exp[i]));
            check_output("oneshot busy2", 128'(busy[2]), 128'(busy_exp[i]));
            idle_inputs();
        end

        // Reload channel 1 while its timer is at 1: collision, no gap.
        load_channel(1, 8'hFF);
        apply_stimulus("reload_start");
        idle_inputs();
        apply_stimulus("reload_t2");
        apply_stimulus("reload_t1");
        load_channel(1, 8'hFF);
        apply_stimulus("reload_hit");
        check_output("reload_hit collision", 128'(collision), 128'(1'b1));
        check_output("reload_hit byte1", 128'(ser_data[15:8]), 128'(8'hFF));
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus("reload_hold");
            check_output("reload_hold byte1", 128'(ser_data[15:8]), 128'(8'hFF));
        end
        apply_stimulus("reload_end");

        // Zero hold length: one cycle of the loaded word, then zeros.
        hold_len = 16'd0;
        load_channel(2, 8'hC3);
        apply_stimulus("hold0_load");
        idle_inputs();
        apply_stimulus("hold0_after");
        check_output("hold0_after byte2", 128'(ser_data[23:16]), 128'(8'h00));

        // Override during a one-shot, with data_valid also asserted.
        mode_oneshot = 8'h01;
        hold_len     = 16'd4;
        load_channel(0, 8'hFF);
        apply_stimulus("ovr_pre");
        override_en    = 1'b1;
        override_value = 8'hA5;
        data_valid     = 1'b1;
        ch_mask        = '1;
        data_in        = 64'h0123_4567_89AB_CDEF;
        apply_stimulus("ovr_on");
`ifdef TTL_OUT_OVERRIDE_EN
        check_output("ovr_on words", 128'(ser_data), 128'(64'hFF00_FF00_00FF_00FF));
        check_output("ovr_on busy", 128'(busy), 128'(8'h00));
`endif
        override_en = 1'b0;
        idle_inputs();
        for (int i = 0; i < 5; i++) apply_stimulus("ovr_off");

        // Asynchronous reset in the middle of a one-shot.
        hold_len = 16'd5;
        load_channel(0, 8'hFF);
        apply_stimulus("areset_pre");
        idle_inputs();
        apply_stimulus("areset_run");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_output("areset ser_data", 128'(ser_data), 128'(0));
        check_output("areset busy", 128'(busy), 128'(0));
        check_output("areset level", 128'(level), 128'(0));
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic with short hold lengths so pulses complete often.
        for (int i = 0; i < 400; i++) begin
            data_valid = ($urandom_range(0, 1) == 1);
            ch_mask    = NUM_CH'($urandom);
            data_in    = {$urandom, $urandom};
            hold_len   = LEN_W'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) mode_oneshot = NUM_CH'($urandom);
            if ($urandom_range(0, 7) == 0)  invert = NUM_CH'($urandom);
            override_en    = ($urandom_range(0, 9) == 0);
            override_value = NUM_CH'($urandom);
            apply_stimulus("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttl_out_array.md
TTL_OUT_ARRAY -- requirements
Module: ttl_out_array

Interface
REQ-001 Parameter NUM_CH, default 8, number of TTL channels (1..16).
REQ-002 Parameter SER_WIDTH, default 8, serializer word bits per channel per clk cycle (4 or 8).
REQ-003 Parameter LEN_W, default 16, width of the one-shot hold counter.
REQ-004 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_valid  input  1  qualifies data_in and ch_mask for this cycle.
REQ-007 data_in  input  NUM_CH*SER_WIDTH  channel c word at [c*SER_WIDTH +: SER_WIDTH]; bit 0 is serialized first.
REQ-008 ch_mask  input  NUM_CH  per-channel load enable.
REQ-009 mode_oneshot  input  NUM_CH  1 = one-shot mode, 0 = level mode.
REQ-010 invert  input  NUM_CH  per-channel output polarity inversion.
REQ-011 hold_len  input  LEN_W  one-shot high-hold length in clk cycles, shared by all channels.
REQ-012 override_en  input  1  forces all channels to override_value.
REQ-013 override_value  input  NUM_CH  per-channel forced level.
REQ-014 ser_data  output  NUM_CH*SER_WIDTH  registered parallel words for the external serializers.
REQ-015 level  output  NUM_CH  registered current idle level per channel, after inversion.
REQ-016 busy  output  NUM_CH  one-shot hold timer running.
REQ-017 collision  output  1  one-cycle pulse when a load hits a busy channel.

Function
REQ-018 Latency SHALL be exactly one clk cycle from the sampled inputs to ser_data, level, busy and collision.
REQ-019 Load: data_valid & ch_mask[c] & !override_en SHALL set word[c]=data slice and last[c]=slice bit SER_WIDTH-1.
REQ-020 No load: word[c] SHALL be {SER_WIDTH{last[c]}}; last[c] holds, except as modified by REQ-022.
REQ-021 One-shot load with last bit 1: timer[c]<=hold_len. One-shot load with last bit 0: timer[c]<=0. Level mode: timer[c] is always 0.
REQ-022 One-shot, no-load cycle, timer[c]!=0: timer decrements. On the cycle the timer reaches 0, last[c]<=0, so output returns low the following cycle.
REQ-023 hold_len=0 in one-shot: the channel SHALL output the loaded word for one cycle, then all zeros.
REQ-024 busy[c] SHALL equal (timer[c]!=0).
REQ-025 A load to a channel with busy[c]=1 SHALL be accepted and reload the timer. collision SHALL pulse for one cycle; multiple hits in one cycle give one pulse.
REQ-026 Output: ser_data slice SHALL be word[c] ^ {SER_WIDTH{invert[c]}}; level[c] SHALL be last[c]^invert[c]; invert is sampled per cycle.
REQ-027 Override (when compiled in): word[c]={SER_WIDTH{override_value[c]}}, last[c]=override_value[c], all timers cleared, data_valid ignored, collision=0.
REQ-028 Mode change while busy SHALL take effect next cycle: switching to level mode clears the timer and keeps last[c].

Reset
REQ-029 While reset=1, asynchronously: ser_data=0, level=0, busy=0, collision=0, all last[c]=0, all timers=0, independent of invert.
REQ-030 On the first clk edge after reset deassertion, outputs SHALL reflect the inputs per REQ-018..REQ-028.

Configuration
REQ-031 Macro TTL_OUT_OVERRIDE_EN defined: REQ-027 is implemented.
REQ-032 Macro undefined: override_en and override_value SHALL remain as ports but be ignored; no override logic is synthesized.

Verification
REQ-033 NUM_CH=8, SER_WIDTH=8, level mode: load ch0=0xF0 -> next cycle ser_data[7:0]=0xF0, then 0xFF held, level[0]=1.
REQ-034 One-shot, hold_len=3: load ch2=0x80 -> 0x80, 0xFF, 0xFF, 0xFF, then 0x00. busy[2] is high for 3 cycles.
REQ-035 One-shot ch1 busy, reload 0xFF at timer=1 -> collision pulses once, timer reloads to hold_len, no drop to 0.
REQ-036 invert[3]=1, no loads after reset -> ser_data[31:24]=0x00 during reset, 0xFF after, level[3]=1.
REQ-037 With TTL_OUT_OVERRIDE_EN: override_en=1, value=0xA5 during a one-shot -> words 0xFF/0x00 per bit, busy=0, data_valid ignored. Without the macro: no effect.
REQ-038 Reset asserted mid one-shot -> all outputs 0 immediately, without waiting for a clk edge.
